// File: rtl/char_demux8_buffer_if.sv
// Write/rotate bus for the eight-slot character buffer feeding the display mux.
// Optional Dir signal present when CHAR_BUF_ROTDIR_EN is defined.
interface char_demux8_buffer_if #(
    parameter int W = 3
);
    logic         Clr;
    logic [W-1:0] D;
    logic [2:0]   S;
    logic         Auto;
    logic         Valid;
    logic         Ready;
    logic         Tick;
    logic         RotEn;
`ifdef CHAR_BUF_ROTDIR_EN
    logic         Dir;
`endif
    logic [W-1:0] A, B, C, D_o, E, F, G, H;
    logic [2:0]   Ptr;
    logic [2:0]   Pos;
    logic         Full;

    modport master (
`ifdef CHAR_BUF_ROTDIR_EN
        output Dir,
`endif
        output Clr, D, S, Auto, Valid, Tick, RotEn,
        input  Ready, A, B, C, D_o, E, F, G, H, Ptr, Pos, Full
    );

    modport slave (
`ifdef CHAR_BUF_ROTDIR_EN
        input  Dir,
`endif
        input  Clr, D, S, Auto, Valid, Tick, RotEn,
        output Ready, A, B, C, D_o, E, F, G, H, Ptr, Pos, Full
    );
endinterface

// File: rtl/char_demux8_buffer.sv
// Eight-slot registered character buffer with auto/manual write and rotation.
// Define CHAR_BUF_ROTDIR_EN to add the Dir input (right rotation when Dir=1).
module char_demux8_buffer #(
    parameter int           W     = 3,
    parameter logic [W-1:0] BLANK = '1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    char_demux8_buffer_if.slave   bus
);

    logic [W-1:0] slot_q [8];
    logic [W-1:0] slot_d [8];
    logic [2:0]   ptr_q, ptr_d;
    logic [2:0]   pos_q, pos_d;
    logic         full_q, full_d;

    logic         ready;
    logic         write_en;
    logic         rotate;
    logic         rot_right;
    logic [2:0]   target;

    always_comb begin
        ready    = !(bus.Auto && full_q);
        write_en = bus.Valid && ready;
        rotate   = bus.Tick && bus.RotEn;
`ifdef CHAR_BUF_ROTDIR_EN
        rot_right = bus.Dir;
`else
        rot_right = 1'b0;
`endif
        target   = bus.Auto ? ptr_q : bus.S;

        for (int unsigned i = 0; i < 8; i++) begin
            slot_d[i] = slot_q[i];
        end
        ptr_d  = ptr_q;
        pos_d  = pos_q;
        full_d = full_q;

        if (rotate) begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot_d[i] = rot_right ? slot_q[3'(i + 7)] : slot_q[3'(i + 1)];
            end
            pos_d = rot_right ? pos_q - 3'd1 : pos_q + 3'd1;
        end

        // Write lands after rotation, so it overrides whatever rotated into T.
        if (write_en) begin
            slot_d[target] = bus.D;
            if (bus.Auto) begin
                ptr_d = ptr_q + 3'd1;
                if (ptr_q == 3'd7) begin
                    full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || bus.Clr) begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot_q[i] <= BLANK;
            end
            ptr_q  <= '0;
            pos_q  <= '0;
            full_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
            ptr_q  <= ptr_d;
            pos_q  <= pos_d;
            full_q <= full_d;
        end
    end

    assign bus.Ready = ready;
    assign bus.A     = slot_q[0];
    assign bus.B     = slot_q[1];
    assign bus.C     = slot_q[2];
    assign bus.D_o   = slot_q[3];
    assign bus.E     = slot_q[4];
    assign bus.F     = slot_q[5];
    assign bus.G     = slot_q[6];
    assign bus.H     = slot_q[7];
    assign bus.Ptr   = ptr_q;
    assign bus.Pos   = pos_q;
    assign bus.Full  = full_q;

endmodule

// File: tb/tb_char_demux8_buffer.sv
// Directed bench for char_demux8_buffer: reset, auto fill, manual write, rotation, clear.
module tb_char_demux8_buffer;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    char_demux8_buffer_if #(.W(3)) bus ();

    char_demux8_buffer #(.W(3), .BLANK(3'b111)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    function automatic logic [2:0] slot(input int unsigned i);
        case (i)
            0: return bus.A;
            1: return bus.B;
            2: return bus.C;
            3: return bus.D_o;
            4: return bus.E;
            5: return bus.F;
            6: return bus.G;
            default: return bus.H;
        endcase
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.Clr   = 1'b0;
        bus.Valid = 1'b0;
        bus.Tick  = 1'b0;
        bus.RotEn = 1'b0;
        bus.Auto  = 1'b0;
        bus.S     = 3'd0;
        bus.D     = 3'd0;
`ifdef CHAR_BUF_ROTDIR_EN
        bus.Dir   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [2:0] exp_blank;
        exp_blank = 3'b111;
        idle();
        Reset = 1'b1; bus.Valid = 1'b1; bus.Tick = 1'b1; bus.RotEn = 1'b1;
        bus.Auto = 1'b1; bus.D = 3'd2;
        step();
        Reset = 1'b0; bus.Valid = 1'b0; bus.Tick = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== exp_blank) begin
                errors++;
                $display("FAIL reset_slot%0d: got %b expected %b", i, slot(i), exp_blank);
            end
        end
        checks++;
        if ({bus.Ptr, bus.Pos, bus.Full, bus.Ready} !== {3'd0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctrl: ptr=%0d pos=%0d full=%b ready=%b expected 0 0 0 1",
                     bus.Ptr, bus.Pos, bus.Full, bus.Ready);
        end
    endtask

    task automatic test_auto_fill();
        idle();
        bus.Auto = 1'b1; bus.Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.D = 3'(i);
            step();
            if (i == 6) begin
                checks++;
                if (bus.Full !== 1'b0 || bus.Ptr !== 3'd7) begin
                    errors++;
                    $display("FAIL fill_before_full: full=%b ptr=%0d expected 0 7", bus.Full, bus.Ptr);
                end
            end
        end
        checks++;
        if ({bus.Full, bus.Ready, bus.Ptr} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL fill_full: full=%b ready=%b ptr=%0d expected 1 0 0",
                     bus.Full, bus.Ready, bus.Ptr);
        end
        bus.D = 3'd5;
        step();
        bus.Valid = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== 3'(i)) begin
                errors++;
                $display("FAIL fill_slot%0d: got %0d expected %0d", i, slot(i), i);
            end
        end
        checks++;
        if ({bus.Full, bus.Ptr} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL fill_ninth_ignored: full=%b ptr=%0d expected 1 0", bus.Full, bus.Ptr);
        end
    endtask

    task automatic test_manual_overwrite();
        logic [2:0] exp [8];
        exp = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd4, 3'd5, 3'd6, 3'd7};
        idle();
        #1;
        checks++;
        if (bus.Ready !== 1'b1) begin
            errors++;
            $display("FAIL manual_ready: got %b expected 1", bus.Ready);
        end
        bus.S = 3'd3; bus.D = 3'd6; bus.Valid = 1'b1;
        step();
        bus.Valid = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== exp[i]) begin
                errors++;
                $display("FAIL manual_slot%0d: got %0d expected %0d", i, slot(i), exp[i]);
            end
        end
        checks++;
        if ({bus.Ptr, bus.Full} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL manual_ctrl: ptr=%0d full=%b expected 0 1", bus.Ptr, bus.Full);
        end
        // restore slot 3 for the rotation tests
        bus.D = 3'd3; bus.Valid = 1'b1;
        step();
        bus.Valid = 1'b0;
    endtask

    task automatic test_rotate_wrap();
        idle();
        bus.Tick = 1'b1;
        step();
        bus.Tick = 1'b0;
        checks++;
        if (bus.A !== 3'd0 || bus.Pos !== 3'd0) begin
            errors++;
            $display("FAIL rot_disabled: A=%0d pos=%0d expected 0 0", bus.A, bus.Pos);
        end
        bus.RotEn = 1'b1;
        for (int p = 1; p <= 8; p++) begin
            bus.Tick = 1'b1;
            step();
            if (p == 1) begin
                checks++;
                if ({bus.A, bus.H, bus.Pos} !== {3'd1, 3'd0, 3'd1}) begin
                    errors++;
                    $display("FAIL rot_first: A=%0d H=%0d pos=%0d expected 1 0 1",
                             bus.A, bus.H, bus.Pos);
                end
            end
        end
        bus.Tick = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== 3'(i)) begin
                errors++;
                $display("FAIL rot_wrap_slot%0d: got %0d expected %0d", i, slot(i), i);
            end
        end
        checks++;
        if (bus.Pos !== 3'd0) begin
            errors++;
            $display("FAIL rot_wrap_pos: got %0d expected 0", bus.Pos);
        end
    endtask

    task automatic test_write_and_rotate();
        logic [2:0] exp [8];
        exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4};
        idle();
        bus.Tick = 1'b1; bus.RotEn = 1'b1; bus.Valid = 1'b1; bus.S = 3'd7; bus.D = 3'd4;
        step();
        idle();
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== exp[i]) begin
                errors++;
                $display("FAIL wr_rot_slot%0d: got %0d expected %0d", i, slot(i), exp[i]);
            end
        end
        checks++;
        if (bus.Pos !== 3'd1) begin
            errors++;
            $display("FAIL wr_rot_pos: got %0d expected 1", bus.Pos);
        end
    endtask

`ifdef CHAR_BUF_ROTDIR_EN
    task automatic test_rotate_right();
        // slots are 1,2,3,4,5,6,7,4 with Pos=1 from the previous test
        logic [2:0] exp [8];
        exp = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        idle();
        bus.Dir = 1'b1; bus.Tick = 1'b1; bus.RotEn = 1'b1;
        bus.Valid = 1'b1; bus.S = 3'd0; bus.D = 3'd5;
        step();
        idle();
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== exp[i]) begin
                errors++;
                $display("FAIL rot_right_slot%0d: got %0d expected %0d", i, slot(i), exp[i]);
            end
        end
        checks++;
        if (bus.Pos !== 3'd0) begin
            errors++;
            $display("FAIL rot_right_pos: got %0d expected 0", bus.Pos);
        end
    endtask
`endif

    task automatic test_clr_mid_operation();
        idle();
        bus.Clr = 1'b1;
        step();
        bus.Clr = 1'b0; bus.Auto = 1'b1; bus.Valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.D = 3'(i);
            step();
        end
        checks++;
        if ({bus.Ptr, bus.Full, bus.A, bus.E} !== {3'd5, 1'b0, 3'd1, 3'd5}) begin
            errors++;
            $display("FAIL clr_setup: ptr=%0d full=%b A=%0d E=%0d expected 5 0 1 5",
                     bus.Ptr, bus.Full, bus.A, bus.E);
        end
        bus.Clr = 1'b1; bus.D = 3'd2; bus.Tick = 1'b1; bus.RotEn = 1'b1;
        step();
        bus.Clr = 1'b0; bus.Tick = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            checks++;
            if (slot(i) !== 3'b111) begin
                errors++;
                $display("FAIL clr_slot%0d: got %b expected 111", i, slot(i));
            end
        end
        checks++;
        if ({bus.Ptr, bus.Pos, bus.Full} !== {3'd0, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr_ctrl: ptr=%0d pos=%0d full=%b expected 0 0 0",
                     bus.Ptr, bus.Pos, bus.Full);
        end
        bus.D = 3'd3;
        step();
        bus.Valid = 1'b0;
        checks++;
        if ({bus.A, bus.B, bus.Ptr} !== {3'd3, 3'b111, 3'd1}) begin
            errors++;
            $display("FAIL clr_next_write: A=%0d B=%0d ptr=%0d expected 3 7 1",
                     bus.A, bus.B, bus.Ptr);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_auto_fill();
        test_manual_overwrite();
        test_rotate_wrap();
        test_write_and_rotate();
`ifdef CHAR_BUF_ROTDIR_EN
        test_rotate_right();
`endif
        test_clr_mid_operation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_demux8_buffer.md
Name: char_demux8_buffer

Overview:
- Write-side counterpart of the 3-bit 8-to-1 character multiplexer used in the Lab A display path.
- Accepts one 3-bit character code per transfer and steers it to one of eight registered slots (A..H). Slot select is either an explicit address or an internal auto-increment pointer.
- The eight slot outputs feed the mux inputs directly.
- Supports whole-buffer rotation on a tick, so a message can scroll across the HEX displays.

Parameters:
- W, 3, character width in bits; every slot, D and every output slot is W bits.
- BLANK, 3'b111, value loaded into every slot on Reset and Clr.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Clr  input  1  synchronous clear: slots to BLANK, pointer/count/Pos to 0.
- D  input  W  character code to write.
- S  input  3  slot address for manual writes (0=A ... 7=H).
- Auto  input  1  1: write address from internal pointer Ptr; 0: from S.
- Valid  input  1  write request; transfer occurs when Valid && Ready at the clock edge.
- Ready  output  1  buffer can accept a write.
- Tick  input  1  single-cycle rotate strobe.
- RotEn  input  1  enables rotation on Tick.
- A, B, C, D_o, E, F, G, H  output  W each  registered slot contents, slots 0..7 (D_o avoids clash with input D).
- Ptr  output  3  auto-write pointer.
- Pos  output  3  rotation offset, incremented modulo 8 per rotation.
- Full  output  1  8 auto-mode writes accepted since last Reset/Clr.

Behaviour:
- Reset (sync, highest priority): all slots = BLANK, Ptr = 0, Pos = 0, Full = 0, Ready = 1.
- Clr: same effect as Reset, priority below Reset and above all other inputs.
- Ready:
  - Combinational: Ready = !(Auto && Full).
  - Manual mode (Auto=0) is always ready; overwrites are allowed.
- Write (Valid && Ready):
  - Target address T = Auto ? Ptr : S.
  - Slot T takes D at the edge; latency 1 clock to the output.
  - In auto mode, Ptr increments modulo 8 (7 -> 0).
  - Full sets on the 8th accepted auto write, i.e. the one at Ptr=7.
  - Manual writes change neither Ptr nor Full.
- Rotate (Tick && RotEn):
  - All slots shift one position left: A<=B, B<=C, ... G<=H, H<=A.
  - Pos increments modulo 8.
  - Tick with RotEn=0 has no effect.
- Simultaneous write and rotate in the same cycle:
  - The rotation is applied first.
  - The written character then overrides the post-rotation slot T, so output slot T shows D next cycle.
  - The value that would have rotated into T is lost.
- Full with Auto=1:
  - Ready=0, so Valid is ignored and Ptr holds at 0.
  - Rotation still operates.
  - Switching Auto to 0 restores Ready in the same cycle.
- Mode change: changing Auto mid-stream does not disturb Ptr.
- All outputs are registered except Ready.

Optional Feature:
- Macro: CHAR_BUF_ROTDIR_EN.
- When defined:
  - Adds input Dir (1 bit).
  - Dir=1 rotates right (A<=H, B<=A, ... H<=G) and decrements Pos modulo 8.
  - Dir=0 behaves as the base left rotation.
  - The write-override rule for simultaneous write and rotate applies in both directions.
- When undefined: no Dir port; rotation is left only.

Test Plan:
- Reset/clear:
  - Stimulus: assert Reset 1 cycle with Valid=1, Tick=1.
  - Required: all slots = 3'b111, Ptr=0, Pos=0, Full=0, Ready=1, no write or rotate taken.
- Auto fill and Full:
  - Stimulus: Auto=1, 8 back-to-back Valid writes with D=0..7, then a 9th write with D=5.
  - Required: A..H = 0..7; Full=1 after the 8th edge; Ready=0; 9th write ignored; Ptr=0.
- Manual overwrite:
  - Stimulus: after the fill above, Auto=0, S=3, D=6, Valid for 1 cycle.
  - Required: D_o=6 on the next cycle, other slots unchanged, Ptr and Full unchanged.
- Rotation wrap:
  - Stimulus: slots 0..7, RotEn=1, 8 Tick pulses.
  - Required: after the 1st pulse A=1, H=0, Pos=1; after the 8th pulse slots are back to 0..7 and Pos=0.
- Simultaneous write and rotate:
  - Stimulus: slots 0..7, one cycle with Tick=1, RotEn=1, Valid=1, Auto=0, S=7, D=4.
  - Required: A..G = 1..7, H=4 (not 0), Pos=1.
- Clr mid-operation:
  - Stimulus: Clr during an auto write with Ptr=5, Full=0.
  - Required: write discarded; all slots BLANK; Ptr=0; a write on the next cycle lands in A.
